// File: rtl/da_sched.sv
// Sequencing controller for the 8-bank distributed-arithmetic FIR datapath.
// Owns the 64-tap delay line, issues MSB-first bit-slices and arbitrates coefficient writes.

module da_sched_bank #(
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_shift,
    input  logic [DW-1:0]           i_din,
    input  logic [$clog2(DW)-1:0]   i_sel,
    output logic [DW-1:0]           o_last,
    output logic [7:0]              o_slice
);
    logic [7:0][DW-1:0] r_tap;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_tap <= '0;
        else if (i_shift)
            r_tap <= {r_tap[6:0], i_din};
    end

    assign o_last = r_tap[7];

    always_comb begin
        o_slice = '0;
        for (int j = 0; j < 8; j++)
            o_slice[j] = r_tap[j][i_sel];
    end
endmodule

module da_sched #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 64,
    parameter int CGAP    = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          c_valid,
    output logic          c_ready,
    input  logic [10:0]   c_addr,
    input  logic [19:0]   c_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [38:0]   y_data,
    output logic          err,
    output logic [63:0]   da_A,
    output logic [19:0]   da_cin,
    output logic [10:0]   da_caddr,
    output logic          da_cload,
    output logic          da_start,
    output logic          da_valid_in,
    output logic          da_reset,
    input  logic          da_valid_out,
    input  logic [38:0]   da_acc
);
    localparam int SW = $clog2(DW);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(CGAP + 2);
    localparam logic [SW-1:0] SL_TOP  = SW'(DW - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(CGAP);

    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, CAPTURE, OUT} state_t;

    state_t            r_state, w_next;
    logic [SW-1:0]     r_slice;
    logic [TW-1:0]     r_to;
    logic [GW-1:0]     r_cgap;
    logic [63:0]       r_da_A;
    logic [19:0]       r_da_cin;
    logic [10:0]       r_da_caddr;
    logic              r_da_cload, r_da_start, r_da_reset, r_da_valid_in;
    logic              r_y_valid, r_err;
    logic [38:0]       r_y_data;

    logic              w_c_acc, w_s_acc, w_to_hit;
    logic [63:0]       w_slice;
    logic [8:0][DW-1:0] w_chain;
    logic              w_unused_tail;

    // Both handshakes are masked during reset so every output reads 0.
    assign c_ready = resetn && (r_state == IDLE) && (r_cgap == '0);
    assign s_ready = c_ready && !c_valid;
    assign w_c_acc = c_valid && c_ready;
    assign w_s_acc = s_valid && s_ready;
    assign w_to_hit = (r_state == WAIT) && !da_valid_out && (r_to == TO_LAST);

    // The delay line is eight chained banks; bank k holds taps 8k..8k+7.
    assign w_chain[0]    = s_data;
    assign w_unused_tail = ^w_chain[8];

    for (genvar k = 0; k < 8; k++) begin : g_bank
        da_sched_bank #(.DW(DW)) u_bank (
            .clk     (clk),
            .resetn  (resetn),
            .i_shift (w_s_acc),
            .i_din   (w_chain[k]),
            .i_sel   (r_slice),
            .o_last  (w_chain[k+1]),
            .o_slice (w_slice[8*k +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_s_acc) w_next = CLR;
            CLR:     w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (da_valid_out)
                    w_next = (r_slice == '0) ? CAPTURE : ISSUE;
                else if (w_to_hit)
                    w_next = IDLE;
            end
            CAPTURE: w_next = OUT;
            OUT:     if (y_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_slice       <= SL_TOP;
            r_to          <= '0;
            r_cgap        <= '0;
            r_da_A        <= '0;
            r_da_cin      <= '0;
            r_da_caddr    <= '0;
            r_da_cload    <= 1'b0;
            r_da_start    <= 1'b0;
            r_da_reset    <= 1'b0;
            r_da_valid_in <= 1'b0;
            r_y_valid     <= 1'b0;
            r_y_data      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_da_cload <= w_c_acc;
            r_da_caddr <= w_c_acc ? c_addr : '0;
            r_da_cin   <= w_c_acc ? c_data : '0;

            if (w_c_acc)
                r_cgap <= GAP_LD;
            else if (r_cgap != '0)
                r_cgap <= r_cgap - 1'b1;

            r_da_start    <= (r_state == CLR);
            r_da_reset    <= (r_state == CLR);
            r_da_valid_in <= (r_state == ISSUE);

            if (r_state == CLR)
                r_slice <= SL_TOP;
            else if (r_state == WAIT && da_valid_out && r_slice != '0)
                r_slice <= r_slice - 1'b1;

            // da_A is captured once per slice and held until the next ISSUE.
            if (r_state == ISSUE) begin
                r_da_A <= w_slice;
                r_to   <= '0;
            end else if (r_state == WAIT) begin
                r_to <= r_to + 1'b1;
            end

            if (w_to_hit)
                r_err <= 1'b1;

            if (r_state == CAPTURE) begin
                r_y_data  <= da_acc;
                r_y_valid <= 1'b1;
            end else if (r_state == OUT && y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign da_A        = r_da_A;
    assign da_cin      = r_da_cin;
    assign da_caddr    = r_da_caddr;
    assign da_cload    = r_da_cload;
    assign da_start    = r_da_start;
    assign da_reset    = r_da_reset;
    assign da_valid_in = r_da_valid_in;
    assign y_valid     = r_y_valid;
    assign y_data      = r_y_data;
    assign err         = r_err;
endmodule
